// File: rtl/cpu_trace_buffer.sv
// Trace capture for the multi-cycle CPU: one 42-bit entry per control-FSM state change,
// armed/triggered capture window, drained through a valid/ready read port.
module cpu_trace_buffer #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int POST_CNT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      state_in,
    input  logic [5:0]      decode_in,
    input  logic            zero_in,
    input  logic [31:0]     pc_in,
    input  logic            arm,
    input  logic [31:0]     trig_pc,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [41:0]     rd_data,
    output logic [AW:0]     count,
    output logic            overflow,
    output logic [1:0]      trc_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TRIG  = 2'd2,
        S_DONE  = 2'd3
    } trc_state_t;

    trc_state_t      r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow;
    logic            r_first;
    logic [2:0]      r_prev_state;
    logic [AW-1:0]   r_post;
    logic [41:0]     r_rd_data;
    logic [41:0]     r_mem [DEPTH];

    logic            w_capturing;
    logic            w_sample;
    logic            w_full;
    logic            w_pop;
    logic            w_lost;
    logic            w_wr_en;
    logic            w_rd_adv;
    logic [41:0]     w_entry;
    logic [AW-1:0]   w_rd_ptr_next;
    logic [41:0]     w_head_next;

    assign w_capturing = (r_state == S_ARMED) || (r_state == S_TRIG);
    // arm wins over everything else in its cycle: no sample, no pop
    assign w_sample    = w_capturing && !arm && (r_first || (state_in != r_prev_state));
    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_pop       = rd_valid && rd_ready && !arm;
    assign w_lost      = w_sample && w_full && !w_pop;
    // Pre-trigger history is a ring (drop oldest); post-trigger keeps the oldest data.
    assign w_wr_en     = w_sample && (!w_full || w_pop || (r_state == S_ARMED));
    assign w_rd_adv    = w_pop || (w_lost && (r_state == S_ARMED));
    assign w_entry     = {state_in, decode_in, zero_in, pc_in};

    assign w_rd_ptr_next = arm ? '0 : (w_rd_adv ? r_rd_ptr + AW'(1) : r_rd_ptr);
    // Bypass covers a write landing on the slot that becomes the head (empty, or 1 entry + pop).
    assign w_head_next   = (w_wr_en && (r_wr_ptr == w_rd_ptr_next)) ? w_entry : r_mem[w_rd_ptr_next];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_first      <= 1'b0;
            r_prev_state <= 3'b000;
            r_post       <= '0;
            r_rd_data    <= '0;
        end else begin
            r_prev_state <= state_in;
            r_rd_data    <= w_head_next;
            r_rd_ptr     <= w_rd_ptr_next;
            if (arm) begin
                r_state    <= S_ARMED;
                r_first    <= 1'b1;
                r_overflow <= 1'b0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_wr_en && !w_rd_adv) begin
                    r_count <= r_count + (AW+1)'(1);
                end else if (!w_wr_en && w_rd_adv) begin
                    r_count <= r_count - (AW+1)'(1);
                end
                if (w_lost) begin
                    r_overflow <= 1'b1;
                end
                if (w_sample) begin
                    r_first <= 1'b0;
                    if (r_state == S_ARMED) begin
                        if (pc_in == trig_pc) begin
                            r_state <= S_TRIG;
                            r_post  <= AW'(POST_CNT);
                        end
                    end else begin
                        r_post <= r_post - AW'(1);
                        if (r_post == AW'(1)) begin
                            r_state <= S_DONE;
                        end
                    end
                end
            end
        end
    end

    assign rd_valid  = (r_count != '0);
    assign rd_data   = r_rd_data;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign trc_state = r_state;

endmodule
